// File: rtl/nios_system_motor_out_pkg.sv
// Shared definitions for the motor output PIO: register offsets and watchdog FSM states.
package nios_system_motor_out_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_STATUS   = 3'd1;
    localparam logic [2:0] ADDR_TIMEOUT  = 3'd2;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    typedef enum logic {
        ST_ARMED   = 1'b0,
        ST_TRIPPED = 1'b1
    } wdog_state_t;

endpackage

// File: rtl/nios_system_wdog_counter.sv
// 32-bit watchdog down-counter with synchronous load and count enable.
// expire flags the last counting cycle (count==1 while enabled).
module nios_system_wdog_counter #(
    parameter logic [31:0] RESET_COUNT = 32'd50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [31:0] load_value,
    input  logic        en,
    output logic        expire
);

    logic [31:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= RESET_COUNT;
        end else if (load) begin
            count <= load_value;
        end else if (en && (count != 32'd0)) begin
            count <= count - 32'd1;
        end
    end

    assign expire = en && (count == 32'd1);

endmodule

// File: rtl/nios_system_motor_out.sv
// Avalon-MM output PIO with a software watchdog that forces SAFE_VALUE when writes stop.
// Optional macro NIOS_MOTOR_OUT_READBACK_EN: DATA offset reads back the data register.
module nios_system_motor_out
    import nios_system_motor_out_pkg::*;
#(
    parameter int               WIDTH           = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0,
    parameter logic [WIDTH-1:0] SAFE_VALUE      = '0,
    parameter logic [31:0]      TIMEOUT_DEFAULT = 32'd50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             tripped
);

    wdog_state_t      state, state_next;
    logic [WIDTH-1:0] data, data_next;
    logic [31:0]      timeout_reg;
    logic [31:0]      load_value;
    logic [31:0]      rd_next;
    logic             wr, cnt_load, cnt_en, expire;
    logic [WIDTH-1:0] wd;

    assign wr = chipselect && !write_n;
    assign wd = writedata[WIDTH-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_ARMED;
            data        <= RESET_VALUE;
            timeout_reg <= TIMEOUT_DEFAULT;
            readdata    <= '0;
        end else begin
            state    <= state_next;
            data     <= data_next;
            readdata <= rd_next;
            if (wr && (address == ADDR_TIMEOUT)) begin
                timeout_reg <= writedata;
            end
        end
    end

    always_comb begin
        state_next = state;
        data_next  = data;
        cnt_load   = 1'b0;
        load_value = timeout_reg;
        case (state)
            ST_ARMED: begin
                if (wr) begin
                    case (address)
                        ADDR_DATA:     begin data_next = wd;         cnt_load = 1'b1; end
                        ADDR_OUTSET:   begin data_next = data | wd;  cnt_load = 1'b1; end
                        ADDR_OUTCLEAR: begin data_next = data & ~wd; cnt_load = 1'b1; end
                        ADDR_TIMEOUT:  begin load_value = writedata; cnt_load = 1'b1; end
                        default: ;
                    endcase
                end
                // Any reload in the expiry cycle (kick or new timeout) beats the trip.
                if (expire && !cnt_load) begin
                    data_next  = SAFE_VALUE;
                    state_next = ST_TRIPPED;
                end
            end
            ST_TRIPPED: begin
                if (wr && (address == ADDR_STATUS) && writedata[0]) begin
                    state_next = ST_ARMED;
                    cnt_load   = 1'b1;
                end
            end
        endcase
    end

    assign cnt_en = (state == ST_ARMED) && (timeout_reg != 32'd0);

    nios_system_wdog_counter #(
        .RESET_COUNT (TIMEOUT_DEFAULT)
    ) u_wdog_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (cnt_load),
        .load_value (load_value),
        .en         (cnt_en),
        .expire     (expire)
    );

`ifdef NIOS_MOTOR_OUT_READBACK_EN
    logic [31:0] data_ext;
    always_comb begin
        data_ext             = '0;
        data_ext[WIDTH-1:0]  = data;
    end
`endif

    always_comb begin
        rd_next = '0;
        case (address)
`ifdef NIOS_MOTOR_OUT_READBACK_EN
            ADDR_DATA:    rd_next = data_ext;
`endif
            ADDR_STATUS:  rd_next = {31'd0, (state == ST_TRIPPED)};
            ADDR_TIMEOUT: rd_next = timeout_reg;
            default:      rd_next = '0;
        endcase
    end

    assign out_port = data;
    assign tripped  = (state == ST_TRIPPED);

endmodule

// File: tb/tb_nios_system_motor_out.sv
// Self-checking bench for nios_system_motor_out: register access, watchdog trip/ack, async reset.
module tb_nios_system_motor_out;

    localparam logic [7:0] SAFE = 8'hC3;
    localparam logic [7:0] RSTV = 8'h00;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        tripped;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    nios_system_motor_out #(
        .WIDTH           (8),
        .RESET_VALUE     (RSTV),
        .SAFE_VALUE      (SAFE),
        .TIMEOUT_DEFAULT (32'd50000)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .tripped    (tripped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd_reg(input string tag, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] e;
        address = a;
        exp_q.push_back(exp);
        step(1);
        e = exp_q.pop_front();
        check(tag, readdata, e);
    endtask

    function automatic logic [31:0] data_rb(input logic [7:0] v);
`ifdef NIOS_MOTOR_OUT_READBACK_EN
        return {24'd0, v};
`else
        return 32'd0 & {24'd0, v};
`endif
    endfunction

    initial begin
        int bad;
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        step(1);

        // reset state
        check("rst_out", {24'd0, out_port}, {24'd0, RSTV});
        check("rst_trip", {31'd0, tripped}, 32'd0);
        rd_reg("rst_data", 3'd0, data_rb(RSTV));
        rd_reg("rst_status", 3'd1, 32'd0);
        rd_reg("rst_timeout", 3'd2, 32'd50000);

        // data / set / clear
        wr_reg(3'd0, 32'hFFFF_FFA5);
        check("data_a5", {24'd0, out_port}, 32'hA5);
        wr_reg(3'd4, 32'h0000_000F);
        check("outset", {24'd0, out_port}, 32'hAF);
        wr_reg(3'd5, 32'h0000_0081);
        check("outclear", {24'd0, out_port}, 32'h2E);
        rd_reg("rb_2e", 3'd0, data_rb(8'h2E));
        rd_reg("rd_unused", 3'd3, 32'd0);
        wr_reg(3'd7, 32'hFF);
        check("wr_unused", {24'd0, out_port}, 32'h2E);

        // trip after 10 idle cycles
        wr_reg(3'd2, 32'd10);
        rd_reg("timeout10", 3'd2, 32'd10);
        wr_reg(3'd0, 32'h3C);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_port !== 8'h3C || tripped !== 1'b0) bad++;
            step(1);
        end
        check("hold_10", bad, 0);
        check("trip_out", {24'd0, out_port}, {24'd0, SAFE});
        check("trip_flag", {31'd0, tripped}, 32'd1);
        rd_reg("trip_status", 3'd1, 32'd1);

        // writes ignored while tripped, ack re-arms
        wr_reg(3'd0, 32'hFF);
        check("trip_ignore", {24'd0, out_port}, {24'd0, SAFE});
        check("trip_hold", {31'd0, tripped}, 32'd1);
        wr_reg(3'd1, 32'd1);
        check("ack_flag", {31'd0, tripped}, 32'd0);
        check("ack_safe", {24'd0, out_port}, {24'd0, SAFE});
        wr_reg(3'd0, 32'hFF);
        check("rearm_ff", {24'd0, out_port}, 32'hFF);

        // kick exactly in the expiry cycle
        wr_reg(3'd2, 32'd4);
        step(3);
        wr_reg(3'd0, 32'h11);
        check("edge_kick_flag", {31'd0, tripped}, 32'd0);
        check("edge_kick_out", {24'd0, out_port}, 32'h11);
        step(3);
        check("reload_pre", {31'd0, tripped}, 32'd0);
        step(1);
        check("reload_trip", {31'd0, tripped}, 32'd1);
        check("reload_safe", {24'd0, out_port}, {24'd0, SAFE});

        // watchdog disabled
        wr_reg(3'd1, 32'd1);
        wr_reg(3'd2, 32'd0);
        wr_reg(3'd0, 32'h22);
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            if (tripped !== 1'b0 || out_port !== 8'h22) bad++;
            step(1);
        end
        check("disabled_1000", bad, 0);

        // async reset mid-countdown
        wr_reg(3'd2, 32'd100);
        wr_reg(3'd0, 32'h55);
        step(20);
        check("pre_rst_out", {24'd0, out_port}, 32'h55);
        #3 reset_n = 1'b0;
        #1;
        check("async_out", {24'd0, out_port}, {24'd0, RSTV});
        check("async_trip", {31'd0, tripped}, 32'd0);
        check("async_rd", readdata, 32'd0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        step(1);
        rd_reg("post_rst_data", 3'd0, data_rb(RSTV));
        rd_reg("post_rst_timeout", 3'd2, 32'd50000);
        rd_reg("post_rst_status", 3'd1, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
